// File: rtl/pd_onchip_mem_arbiter.sv
// Two-master round-robin arbiter for a single-port on-chip RAM; one access per cycle, fixed 1-cycle read latency.
// Losing master stalls via waitrequest for at most one cycle; out-of-range accesses are absorbed without touching the RAM.
module pd_onchip_mem_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4,
   parameter int DEPTH  = 25024
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic              req0, req1;
   logic              gnt0, gnt1, any_gnt;
   logic              g_write;
   logic [ADDR_W-1:0] g_addr;
   logic [BE_W-1:0]   g_be;
   logic [DATA_W-1:0] g_wdata;
   logic              in_range;
   logic              rd_accept;

   logic last_gnt_q, last_gnt_d;
   logic rd_pend_q,  rd_pend_d;
   logic rd_owner_q, rd_owner_d;
   logic rd_oor_q,   rd_oor_d;

   // last_gnt_q names the master that won most recently; the other one wins a tie.
   always_comb begin
      req0    = m0_read | m0_write;
      req1    = m1_read | m1_write;
      gnt0    = req0 & (~req1 | last_gnt_q);
      gnt1    = req1 & (~req0 | ~last_gnt_q);
      any_gnt = gnt0 | gnt1;
   end

   always_comb begin
      g_write = 1'b0;
      g_addr  = '0;
      g_be    = '0;
      g_wdata = '0;
      if (gnt0) begin
         g_write = m0_write;
         g_addr  = m0_address;
         g_be    = m0_byteenable;
         g_wdata = m0_writedata;
      end else if (gnt1) begin
         g_write = m1_write;
         g_addr  = m1_address;
         g_be    = m1_byteenable;
         g_wdata = m1_writedata;
      end
   end

   always_comb begin
      in_range       = ({1'b0, g_addr} < DEPTH_L);
      rd_accept      = any_gnt & ~g_write;

      m0_waitrequest = req0 & ~gnt0;
      m1_waitrequest = req1 & ~gnt1;

      mem_address    = g_addr;
      mem_byteenable = g_be;
      mem_writedata  = g_wdata;
      mem_chipselect = any_gnt & in_range;
      mem_write      = any_gnt & g_write & in_range;
      mem_clken      = 1'b1;
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      rd_owner_d = rd_owner_q;
      rd_oor_d   = rd_oor_q;
      rd_pend_d  = rd_accept;
      if (any_gnt) begin
         last_gnt_d = gnt1;
      end
      if (rd_accept) begin
         rd_owner_d = gnt1;
         rd_oor_d   = ~in_range;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q <= 1'b1;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_oor_q   <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

   // Both masters see the same data bus; only the valid strobe is steered.
   always_comb begin
      m0_readdatavalid = rd_pend_q & ~rd_owner_q;
      m1_readdatavalid = rd_pend_q &  rd_owner_q;
      m0_readdata      = (rd_pend_q & ~rd_oor_q) ? mem_readdata : '0;
      m1_readdata      = m0_readdata;
   end

endmodule

// File: tb/tb_pd_onchip_mem_arbiter.sv
// Directed bench for pd_onchip_mem_arbiter with a behavioural 1-cycle-latency RAM model on the memory port.
module tb_pd_onchip_mem_arbiter;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int DEPTH  = 25024;

   logic clk = 1'b0;
   logic reset;

   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pd_onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   function automatic logic [31:0] pre(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // RAM model: unwritten words read back their preload pattern.
   logic [31:0] ram     [0:DEPTH-1];
   bit          wr_seen [0:DEPTH-1];
   logic [31:0] cur, nv;

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         cur = wr_seen[mem_address] ? ram[mem_address] : pre(int'(mem_address));
         if (mem_write) begin
            nv = cur;
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) nv[b*8 +: 8] = mem_writedata[b*8 +: 8];
            ram[mem_address]     <= nv;
            wr_seen[mem_address] <= 1'b1;
         end else begin
            mem_readdata <= cur;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic drv(input int m, input bit rd, input bit wr, input int addr,
                      input logic [3:0] be, input logic [31:0] d);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = ADDR_W'(addr); m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = ADDR_W'(addr); m1_byteenable = be; m1_writedata = d;
      end
   endtask

   // Each step: new inputs at the falling edge, settle, then observe.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #2;
      chk("rst_rdv0",   32'(m0_readdatavalid), 0);
      chk("rst_rdv1",   32'(m1_readdatavalid), 0);
      chk("rst_rdata0", m0_readdata, 0);
      chk("rst_cs",     32'(mem_chipselect), 0);
      chk("rst_wr0",    32'(m0_waitrequest), 0);
      chk("clken",      32'(mem_clken), 1);
      @(negedge clk);
      reset = 1'b0;

      // single master write then read
      idle(); drv(0, 0, 1, 'h10, 4'hF, 32'hA5A5_1234); #1;
      chk("t1_wr_wait", 32'(m0_waitrequest), 0);
      chk("t1_wr_cs",   32'(mem_chipselect), 1);
      chk("t1_wr_we",   32'(mem_write), 1);
      chk("t1_wr_addr", 32'(mem_address), 'h10);
      step(); idle(); drv(0, 1, 0, 'h10, 4'hF, 0); #1;
      chk("t1_rd_wait", 32'(m0_waitrequest), 0);
      chk("t1_rd_we",   32'(mem_write), 0);
      chk("t1_rd_rdv0", 32'(m0_readdatavalid), 0);
      step(); idle(); #1;
      chk("t1_rdv0",    32'(m0_readdatavalid), 1);
      chk("t1_rdv1",    32'(m1_readdatavalid), 0);
      chk("t1_data",    m0_readdata, 32'hA5A5_1234);
      chk("t1_idle_cs", 32'(mem_chipselect), 0);
      step(); #1;
      chk("t1_rdv0_off", 32'(m0_readdatavalid), 0);

      // byte lanes
      idle(); drv(0, 0, 1, 3, 4'hF, 32'hFFFF_FFFF);
      step(); idle(); drv(0, 0, 1, 3, 4'h5, 32'h0000_0000);
      step(); idle(); drv(0, 1, 0, 3, 4'hF, 0);
      step(); idle(); #1;
      chk("t2_rdv0", 32'(m0_readdatavalid), 1);
      chk("t2_data", m0_readdata, 32'hFF00_FF00);

      // reset while a read is in flight
      step(); idle(); drv(0, 1, 0, 7, 4'hF, 0); #1;
      chk("t5_cs", 32'(mem_chipselect), 1);
      step(); reset = 1'b1; idle(); #1;
      chk("t5_rdv0_a", 32'(m0_readdatavalid), 0);
      chk("t5_rdata_a", m0_readdata, 0);
      step(); #1;
      chk("t5_rdv0_b", 32'(m0_readdatavalid), 0);
      step(); reset = 1'b0; #1;
      chk("t5_rdv0_c", 32'(m0_readdatavalid), 0);
      step(); #1;
      chk("t5_rdv0_d", 32'(m0_readdatavalid), 0);

      // contention: first tie after reset goes to m0, then alternates
      idle(); drv(0, 1, 0, 20, 4'hF, 0); drv(1, 1, 0, 30, 4'hF, 0); #1;
      chk("t3_c1_wr0",  32'(m0_waitrequest), 0);
      chk("t3_c1_wr1",  32'(m1_waitrequest), 1);
      chk("t3_c1_addr", 32'(mem_address), 20);
      step(); #1;
      chk("t3_c2_wr0",  32'(m0_waitrequest), 1);
      chk("t3_c2_wr1",  32'(m1_waitrequest), 0);
      chk("t3_c2_addr", 32'(mem_address), 30);
      chk("t3_c2_rdv0", 32'(m0_readdatavalid), 1);
      chk("t3_c2_rdv1", 32'(m1_readdatavalid), 0);
      chk("t3_c2_data", m0_readdata, pre(20));
      step(); #1;
      chk("t3_c3_wr0",  32'(m0_waitrequest), 0);
      chk("t3_c3_wr1",  32'(m1_waitrequest), 1);
      chk("t3_c3_rdv0", 32'(m0_readdatavalid), 0);
      chk("t3_c3_rdv1", 32'(m1_readdatavalid), 1);
      chk("t3_c3_data", m1_readdata, pre(30));
      step(); idle(); #1;
      chk("t3_c4_rdv0", 32'(m0_readdatavalid), 1);
      chk("t3_c4_data", m0_readdata, pre(20));
      step(); #1;
      chk("t3_c5_rdv0", 32'(m0_readdatavalid), 0);
      chk("t3_c5_rdv1", 32'(m1_readdatavalid), 0);

      // out of range on m1
      idle(); drv(1, 0, 1, DEPTH, 4'hF, 32'h1111_1111); #1;
      chk("t4_wr_cs",   32'(mem_chipselect), 0);
      chk("t4_wr_we",   32'(mem_write), 0);
      chk("t4_wr_wait", 32'(m1_waitrequest), 0);
      step(); idle(); drv(1, 1, 0, DEPTH, 4'hF, 0); #1;
      chk("t4_rd_cs",   32'(mem_chipselect), 0);
      chk("t4_rd_wait", 32'(m1_waitrequest), 0);
      step(); idle(); drv(1, 1, 0, DEPTH-1, 4'hF, 0); #1;
      chk("t4_rdv1",    32'(m1_readdatavalid), 1);
      chk("t4_rdv0",    32'(m0_readdatavalid), 0);
      chk("t4_data0",   m1_readdata, 0);
      step(); idle(); #1;
      chk("t4_last_rdv", 32'(m1_readdatavalid), 1);
      chk("t4_last",     m1_readdata, pre(DEPTH-1));

      // read and write together is a write
      step(); idle(); drv(1, 1, 1, 5, 4'hF, 32'h0000_0077); #1;
      chk("t6_we", 32'(mem_write), 1);
      chk("t6_cs", 32'(mem_chipselect), 1);
      step(); idle(); drv(1, 1, 0, 5, 4'hF, 0); #1;
      chk("t6_rdv1_none", 32'(m1_readdatavalid), 0);
      chk("t6_rdv0_none", 32'(m0_readdatavalid), 0);
      step(); idle(); #1;
      chk("t6_rdv1", 32'(m1_readdatavalid), 1);
      chk("t6_data", m1_readdata, 32'h0000_0077);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
